// File: rtl/fwd_hazard_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fwd_hazard_if: ID-stage instruction fields in, EX forward selects
// and hazard status out.                                 Rev 1.0
// ------------------------------------------------------------------
interface fwd_hazard_if #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1),
  parameter int CNT_W   = 16
);
  logic                     id_valid;
  logic [NUM_SRC*REG_W-1:0] id_src;
  logic [NUM_SRC-1:0]       id_src_used;
  logic [REG_W-1:0]         id_rd;
  logic                     id_regwrite;
  logic                     id_memread;
  logic                     stall_in;
  logic                     flush;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     hazard_stall;
  logic                     ex_valid;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread,
           stall_in, flush,
    input  fwd_sel, hazard_stall, ex_valid, stall_count
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread,
           stall_in, flush,
    output fwd_sel, hazard_stall, ex_valid, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fwd_hazard_unit: EX-operand forwarding selects and ID load-use
// stall for the pipelined MIPS core.                     Rev 1.0
// ------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int REG_W   = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1),
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  fwd_hazard_if.slave bus
);

  logic                     ex_valid_q;
  logic [NUM_SRC*REG_W-1:0] ex_src;
  logic [NUM_SRC-1:0]       ex_used;
  logic [REG_W-1:0]         ex_rd;
  logic                     ex_regwrite;
  logic                     ex_memread;

  logic [DEPTH:1]           st_valid;
  logic [DEPTH:1]           st_regwrite;
  logic [REG_W-1:0]         st_rd [1:DEPTH];
  logic [DEPTH:1]           st_producer;

  logic [CNT_W-1:0]         stall_cnt;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     ex_load;
  logic                     id_match;
  logic                     hazard;
  logic                     hazard_stall;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_prod
    assign st_producer[k] = st_valid[k] && st_regwrite[k] && (st_rd[k] != '0);
  end

  // Scan oldest to youngest so the youngest matching producer is left in sel.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (ex_valid_q && ex_used[i] && st_producer[k] &&
            (st_rd[k] == ex_src[i*REG_W +: REG_W])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
        end
      end
    end
  end

  assign ex_load = ex_valid_q && ex_regwrite && ex_memread && (ex_rd != '0);

  always_comb begin
    id_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_src_used[i] && (bus.id_src[i*REG_W +: REG_W] == ex_rd)) begin
        id_match = 1'b1;
      end
    end
  end

  assign hazard       = bus.id_valid && ex_load && id_match;
  assign hazard_stall = hazard && !bus.flush;

  // A flush still kills the EX entry while the pipe is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
    end else if (!bus.stall_in) begin
      ex_valid_q  <= bus.id_valid && !hazard_stall && !bus.flush;
      ex_src      <= bus.id_src;
      ex_used     <= bus.id_src_used;
      ex_rd       <= bus.id_rd;
      ex_regwrite <= bus.id_regwrite;
      ex_memread  <= bus.id_memread;
    end else if (bus.flush) begin
      ex_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_valid <= '0;
    end else if (!bus.stall_in) begin
      st_valid[1]    <= ex_valid_q;
      st_regwrite[1] <= ex_regwrite;
      st_rd[1]       <= ex_rd;
      for (int k = 2; k <= DEPTH; k++) begin
        st_valid[k]    <= st_valid[k-1];
        st_regwrite[k] <= st_regwrite[k-1];
        st_rd[k]       <= st_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (hazard_stall && !bus.stall_in && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.fwd_sel      = fwd_sel;
  assign bus.hazard_stall = hazard_stall;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.stall_count  = stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fwd_hazard_unit: directed and random stimulus against an
// instruction-queue reference model.                    Rev 1.0
// ------------------------------------------------------------------
module tb_fwd_hazard_unit;
  localparam int REG_W   = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int SEL_W   = $clog2(DEPTH + 1);
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_hazard_if #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                  .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                    .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: queue of in-flight instructions, index 0 is EX, index k is stage k.
  typedef struct {
    bit                       v;
    logic [NUM_SRC*REG_W-1:0] src;
    logic [NUM_SRC-1:0]       used;
    logic [REG_W-1:0]         rd;
    bit                       rw;
    bit                       mr;
  } ins_t;

  ins_t pipe [$];
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;

  function automatic ins_t blank();
    ins_t z;
    z.v = 0; z.src = '0; z.used = '0; z.rd = '0; z.rw = 0; z.mr = 0;
    return z;
  endfunction

  task automatic m_reset();
    pipe.delete();
    for (int k = 0; k <= DEPTH; k++) pipe.push_back(blank());
    m_cnt = 0;
  endtask

  function automatic bit m_hazard();
    bit h = 0;
    if (bus.id_valid && pipe[0].v && pipe[0].rw && pipe[0].mr && pipe[0].rd != 0)
      for (int i = 0; i < NUM_SRC; i++)
        if (bus.id_src_used[i] && bus.id_src[i*REG_W +: REG_W] == pipe[0].rd) h = 1;
    return h && !bus.flush;
  endfunction

  function automatic logic [31:0] exp_fwd(int i);
    if (!pipe[0].v || !pipe[0].used[i]) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 &&
          pipe[k].rd == pipe[0].src[i*REG_W +: REG_W]) return k;
    return 0;
  endfunction

  task automatic m_clock();
    ins_t n;
    bit   h;
    h = m_hazard();
    if (reset) begin
      m_reset();
      return;
    end
    if (!bus.stall_in) begin
      if (h && m_cnt != CNT_MAX) m_cnt++;
      n.v    = bus.id_valid && !h && !bus.flush;
      n.src  = bus.id_src;
      n.used = bus.id_src_used;
      n.rd   = bus.id_rd;
      n.rw   = bus.id_regwrite;
      n.mr   = bus.id_memread;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end else if (bus.flush) begin
      pipe[0].v = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fsel(int i);
    return 32'(bus.fwd_sel[i*SEL_W +: SEL_W]);
  endfunction

  task automatic check_all(string tag);
    for (int i = 0; i < NUM_SRC; i++)
      chk($sformatf("%s.fwd%0d", tag, i), fsel(i), exp_fwd(i));
    chk({tag, ".stall"}, 32'(bus.hazard_stall), 32'(m_hazard()));
    chk({tag, ".exv"},   32'(bus.ex_valid),     32'(pipe[0].v));
    chk({tag, ".cnt"},   32'(bus.stall_count),  32'(m_cnt));
  endtask

  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] used,
                       input int rd, input bit rw, input bit mr);
    bus.id_valid    = v;
    bus.id_src      = {REG_W'(s1), REG_W'(s0)};
    bus.id_src_used = used;
    bus.id_rd       = REG_W'(rd);
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic tick(string tag);
    check_all(tag);
    @(posedge clk);
    m_clock();
    #1;
  endtask

  initial begin
    int cnt_hold;
    // Reset with garbage on every input.
    reset        = 1'b1;
    bus.stall_in = 1'($urandom);
    bus.flush    = 1'($urandom);
    drive(1, $urandom_range(31), $urandom_range(31), 2'b11, $urandom_range(31), 1, 1);
    @(posedge clk);
    @(posedge clk);
    m_reset();
    #1;
    chk("rst.fwd0", fsel(0), 0);
    chk("rst.fwd1", fsel(1), 0);
    chk("rst.stall", 32'(bus.hazard_stall), 0);
    chk("rst.exv", 32'(bus.ex_valid), 0);
    chk("rst.cnt", 32'(bus.stall_count), 0);
    reset = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
    nop(); tick("idle");

    // add r3 ; sub r4,r3,r5
    drive(1, 1, 2, 2'b11, 3, 1, 0); tick("alu.add");
    drive(1, 3, 5, 2'b11, 4, 1, 0); tick("alu.sub");
    nop();
    chk("alu_mem.fwd0", fsel(0), 1);
    chk("alu_mem.fwd1", fsel(1), 0);
    tick("alu.n0");
    // add r3 ; nop ; sub r4,r3,r5
    drive(1, 1, 2, 2'b11, 3, 1, 0); tick("wb.add");
    nop(); tick("wb.nop");
    drive(1, 3, 5, 2'b11, 4, 1, 0); tick("wb.sub");
    nop();
    chk("alu_wb.fwd0", fsel(0), 2);
    tick("wb.n0");

    // add r3 ; add r3 ; or r6,r3,r3
    drive(1, 1, 2, 2'b11, 3, 1, 0); tick("yw.a1");
    drive(1, 4, 5, 2'b11, 3, 1, 0); tick("yw.a2");
    drive(1, 3, 3, 2'b11, 6, 1, 0); tick("yw.or");
    nop();
    chk("young.fwd0", fsel(0), 1);
    chk("young.fwd1", fsel(1), 1);
    tick("yw.n0");
    // write r0 then read r0
    drive(1, 1, 2, 2'b11, 0, 1, 0); tick("r0.w");
    drive(1, 0, 0, 2'b11, 8, 1, 0); tick("r0.r");
    nop();
    chk("r0.fwd0", fsel(0), 0);
    chk("r0.fwd1", fsel(1), 0);
    tick("r0.n0"); nop(); tick("r0.n1");

    // lw r2 ; add r7,r2,r1
    drive(1, 4, 0, 2'b01, 2, 1, 1); tick("lu.lw");
    drive(1, 2, 1, 2'b11, 7, 1, 0);
    chk("lu.stall1", 32'(bus.hazard_stall), 1);
    tick("lu.s1");
    chk("lu.stall2", 32'(bus.hazard_stall), 0);
    chk("lu.bubble", 32'(bus.ex_valid), 0);
    tick("lu.s2");
    nop();
    chk("lu.fwd0", fsel(0), 2);
    chk("lu.cnt", 32'(bus.stall_count), 1);
    tick("lu.n0");

    // Unused matching source, and a load to r0: neither stalls.
    drive(1, 4, 0, 2'b01, 2, 1, 1); tick("ns.lw");
    drive(1, 2, 1, 2'b10, 7, 1, 0);
    chk("ns.unused", 32'(bus.hazard_stall), 0);
    tick("ns.add");
    drive(1, 4, 0, 2'b01, 0, 1, 1); tick("ns.lw0");
    drive(1, 0, 0, 2'b11, 7, 1, 0);
    chk("ns.r0", 32'(bus.hazard_stall), 0);
    tick("ns.add0");

    // Freeze with a pending load-use, then flush.
    drive(1, 4, 0, 2'b01, 9, 1, 1); tick("fz.lw");
    cnt_hold = m_cnt;
    bus.stall_in = 1'b1;
    drive(1, 9, 1, 2'b11, 10, 1, 0);
    for (int c = 0; c < 3; c++) begin
      chk("fz.stall", 32'(bus.hazard_stall), 1);
      chk("fz.exv", 32'(bus.ex_valid), 1);
      chk("fz.cnt", 32'(bus.stall_count), 32'(cnt_hold));
      tick("fz.hold");
    end
    bus.stall_in = 1'b0; bus.flush = 1'b1; #1;
    chk("fl.stall", 32'(bus.hazard_stall), 0);
    tick("fl.edge");
    bus.flush = 1'b0; nop();
    chk("fl.bubble", 32'(bus.ex_valid), 0);
    chk("fl.cnt", 32'(bus.stall_count), 32'(cnt_hold));
    tick("fl.n0");

    // Reset in the middle of a frozen stall.
    drive(1, 4, 0, 2'b01, 11, 1, 1); tick("rm.lw");
    bus.stall_in = 1'b1;
    drive(1, 11, 1, 2'b11, 12, 1, 0);
    tick("rm.frz");
    reset = 1'b1; tick("rm.rst");
    reset = 1'b0; #1;
    chk("rm.stall", 32'(bus.hazard_stall), 0);
    chk("rm.exv", 32'(bus.ex_valid), 0);
    chk("rm.cnt", 32'(bus.stall_count), 0);
    bus.stall_in = 1'b0;
    nop(); tick("rm.n0");

    // Drive the counter past its maximum.
    for (int p = 0; p < CNT_MAX + 3; p++) begin
      drive(1, 4, 0, 2'b01, 2, 1, 1); tick("sat.lw");
      drive(1, 1, 2, 2'b11, 7, 1, 0); tick("sat.s");
      tick("sat.go");
    end
    chk("sat.cnt", 32'(bus.stall_count), CNT_MAX);
    nop(); tick("sat.n0");

    // Random traffic over a small register window.
    for (int c = 0; c < 600; c++) begin
      reset        = ($urandom_range(199) == 0);
      bus.stall_in = ($urandom_range(7) == 0);
      bus.flush    = ($urandom_range(9) == 0);
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7),
            2'($urandom), $urandom_range(7), 1'($urandom), 1'($urandom));
      tick("rnd");
    end
    reset = 1'b0; bus.stall_in = 1'b0; bus.flush = 1'b0;
    nop(); tick("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
